// File: rtl/tow_pkg.sv
// Shared types and helpers for the tug-of-war scorer: round state, position
// arithmetic and the LED score pattern generator.
package tow_pkg;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        WIN_L = 2'd1,
        WIN_R = 2'd2
    } tow_state_e;

    localparam int MAX_SCORE_W = 64;

    // Signed width that holds -steps..+steps.
    function automatic int pos_width(input int steps);
        return $clog2(steps + 1) + 1;
    endfunction

    // Boost tile index for a rope position: bit i <-> position i-steps.
    function automatic int pos_index(input int p, input int steps);
        return p + steps;
    endfunction

    // LED pattern, MSB = furthest-left; callers truncate to 2*steps+2 bits.
    function automatic logic [MAX_SCORE_W-1:0] score_pattern(input int steps,
                                                             input tow_state_e st,
                                                             input int p);
        logic [MAX_SCORE_W-1:0] pat;
        case (st)
            WIN_L:   pat = ((64'(1) << steps) - 64'(1)) << (steps + 2);
            WIN_R:   pat = (64'(1) << steps) - 64'(1);
            default: begin
                if (p == 0)     pat = 64'(3) << steps;
                else if (p < 0) pat = 64'(1) << (steps + 1 - p);
                else            pat = 64'(1) << (steps - p);
            end
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/tow_score_decode.sv
// Purely combinational decode of round state and rope position into the
// LED score vector.
module tow_score_decode
    import tow_pkg::*;
#(
    parameter  int STEPS   = 3,
    localparam int SCORE_W = 2*STEPS+2,
    localparam int PW      = pos_width(STEPS)
) (
    input  tow_state_e             state,
    input  logic signed [PW-1:0]   pos,
    output logic [SCORE_W-1:0]     score
);

    always_comb begin
        score = SCORE_W'(score_pattern(STEPS, state, int'(pos)));
    end

endmodule

// File: rtl/tow_scorer.sv
// Tug-of-war scorer: rope position, optional boost tiles (TOW_BOOST_EN),
// best-of match game counters and held round wins.
module tow_scorer
    import tow_pkg::*;
#(
    parameter  int STEPS        = 3,
    parameter  int GAMES_TO_WIN = 3,
    localparam int SCORE_W      = 2*STEPS+2,
    localparam int GW           = $clog2(GAMES_TO_WIN+1),
    localparam int PW           = pos_width(STEPS),
    localparam int BW           = 2*STEPS+1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winrnd,
    input  logic                  right,
    input  logic                  leds_on,
    input  logic                  tie,
    input  logic                  next_round,
    input  logic [BW-1:0]         boost_in,
    output logic [SCORE_W-1:0]    score,
    output logic signed [PW-1:0]  pos,
    output logic [GW-1:0]         games_l,
    output logic [GW-1:0]         games_r,
    output logic                  round_won,
    output logic                  winner,
    output logic                  match_over
);

    localparam logic [GW-1:0] GMAX = GW'(GAMES_TO_WIN);

    tow_state_e           state_q, state_d;
    logic signed [PW-1:0] pos_q, pos_d;
    logic [GW-1:0]        games_l_q, games_l_d, games_r_q, games_r_d;
    logic                 round_won_q, round_won_d;
    logic                 winner_q, winner_d;
    logic                 mr;
    int                   step;
    int                   target;

`ifdef TOW_BOOST_EN
    localparam int IW = $clog2(BW);
    logic [BW-1:0] boost_q, boost_d;
    logic [IW-1:0] boost_idx;
    assign boost_idx = IW'(pos_index(int'(pos_q), STEPS));
`else
    logic boost_unused;
    assign boost_unused = ^boost_in;
`endif

    assign match_over = (state_q != PLAY) && (games_l_q == GMAX || games_r_q == GMAX);

    // NOTE: every comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        games_l_d   = games_l_q;
        games_r_d   = games_r_q;
        round_won_d = 1'b0;
        winner_d    = winner_q;
        mr          = (right & leds_on) | (~right & ~leds_on);
        step        = 1;
`ifdef TOW_BOOST_EN
        boost_d = boost_q;
        // Double move only for a proper push by a player at or behind neutral.
        if (leds_on && boost_q[boost_idx] && (mr ? (pos_q <= 0) : (pos_q >= 0)))
            step = 2;
`endif
        target = int'(pos_q) + (mr ? step : -step);

        case (state_q)
            PLAY: begin
`ifdef TOW_BOOST_EN
                if (pos_q == '0) boost_d = boost_in;
`endif
                if (winrnd && !tie) begin
                    if (target > STEPS) begin
                        state_d     = WIN_R;
                        games_r_d   = (games_r_q == GMAX) ? games_r_q : games_r_q + 1'b1;
                        round_won_d = 1'b1;
                        winner_d    = 1'b1;
                    end else if (target < -STEPS) begin
                        state_d     = WIN_L;
                        games_l_d   = (games_l_q == GMAX) ? games_l_q : games_l_q + 1'b1;
                        round_won_d = 1'b1;
                        winner_d    = 1'b0;
                    end else begin
                        pos_d = PW'(target);
                    end
                end
            end
            default: begin
                if (next_round) begin
                    state_d = PLAY;
                    pos_d   = '0;
`ifdef TOW_BOOST_EN
                    boost_d = boost_in;
`endif
                    if (match_over) begin
                        games_l_d = '0;
                        games_r_d = '0;
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PLAY;
            pos_q       <= '0;
            games_l_q   <= '0;
            games_r_q   <= '0;
            round_won_q <= 1'b0;
            winner_q    <= 1'b0;
`ifdef TOW_BOOST_EN
            boost_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            games_l_q   <= games_l_d;
            games_r_q   <= games_r_d;
            round_won_q <= round_won_d;
            winner_q    <= winner_d;
`ifdef TOW_BOOST_EN
            boost_q     <= boost_d;
`endif
        end
    end

    tow_score_decode #(.STEPS(STEPS)) u_decode (
        .state (state_q),
        .pos   (pos_q),
        .score (score)
    );

    assign pos       = pos_q;
    assign games_l   = games_l_q;
    assign games_r   = games_r_q;
    assign round_won = round_won_q;
    assign winner    = winner_q;

endmodule

// File: doc/tow_scorer.md
# tow_scorer

Parametrised tug-of-war scorer for the FPGA-ToW game core. It tracks the rope position across 2·STEPS+1 positions and applies per-position boost (double-move) tiles latched at neutral. It keeps best-of match game counts for both players and holds each round win until the game controller acknowledges it. It sits between the push arbiter (winrnd/right/tie/leds_on) and the LED driver (score).

## Interface
- STEPS, 3: positions per side before a win; ≥1.
- GAMES_TO_WIN, 3: round wins that end a match; ≥1.
- SCORE_W, 2*STEPS+2: derived LED vector width; not overridden.
- GW, $clog2(GAMES_TO_WIN+1): derived game-counter width.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- winrnd  in  1  one-cycle pulse: a push was resolved.
- right  in  1  1 = right player pushed first.
- leds_on  in  1  1 = lights were on (proper push); 0 = jump-the-light.
- tie  in  1  qualifies winrnd; tie suppresses the move.
- next_round  in  1  one-cycle acknowledge from controller to leave a win state.
- boost_in  in  2*STEPS+1  boost tiles; bit i ↔ position i−STEPS.
- score  out  SCORE_W  LED pattern, MSB = furthest-left position.
- pos  out  signed $clog2(STEPS+1)+1  current rope position, −STEPS..+STEPS, + = right.
- games_l, games_r  out  GW  round wins this match.
- round_won  out  1  one-cycle pulse on entry to a win state.
- winner  out  1  last round winner, 1 = right; valid from round_won onward.
- match_over  out  1  high while in a win state with either counter == GAMES_TO_WIN.

## Operation
- States: PLAY, WIN_L, WIN_R.
- Reset: PLAY, pos=0, games 0, boost_q=0, round_won=0, winner=0, match_over=0, score=neutral.
- Move direction: mr = (right & leds_on) | (~right & ~leds_on). mr=1 moves toward +, otherwise toward −.
- Move in PLAY only when winrnd & ~tie. winrnd with tie, or winrnd outside PLAY, is ignored.
- Step is 1, except 2 when all hold:
  - leds_on = 1;
  - boost_q[pos+STEPS] = 1;
  - the mover is at or behind neutral: mr & pos≤0, or ~mr & pos≥0.
- Jump-the-light moves are always step 1.
- Win detection:
  - target > +STEPS → WIN_R, games_r+1, winner=1.
  - target < −STEPS → WIN_L, games_l+1, winner=0.
  - Overshoot by a double step is a win; no error state exists.
  - round_won pulses in the cycle the state becomes WIN_x.
- boost_q loads from boost_in on every clock in PLAY with pos==0. It is frozen otherwise.
- In WIN_x, next_round returns the block to PLAY with pos=0 and boost_q loaded from boost_in that cycle. If match_over was high, games_l/games_r also clear.
- next_round in PLAY is ignored.
- Score decode (k = |pos|):
  - neutral → bits STEPS+1 and STEPS.
  - left k → bit STEPS+1+k.
  - right k → bit STEPS−k.
  - WIN_L → top STEPS bits.
  - WIN_R → bottom STEPS bits.
- Counters never exceed GAMES_TO_WIN; they are cleared only by next_round after match_over, or by rst.

## Timing
- Move latency: pos, score and counters update on the clock edge that samples winrnd; visible the next cycle.
- score, match_over: combinational decode of registered state, pos and counters.
- round_won: registered, high exactly one cycle.
- Leaving a win state: next_round sampled → PLAY and neutral next cycle. A winrnd in that same cycle is ignored.
- rst has priority over every input; rst mid-round or mid-win gives the reset values next cycle.

## Configuration
- TOW_BOOST_EN defined: boost logic as above.
- TOW_BOOST_EN undefined: boost_q and the double-step path are removed. boost_in is unused, and every move is step 1.

## Structure
- Package tow_pkg holds:
  - state enum (PLAY, WIN_L, WIN_R);
  - position type helpers;
  - score-pattern function parametrised by STEPS.
- Sub-module tow_score_decode: state + pos → score vector, purely combinational.

## Test plan
- STEPS=3, after rst: score=00011000, pos=0. Proper right push (winrnd, right=1, leds_on=1) → pos=+1, score=00000100.
- From neutral, boost_in bit 3 set, proper left push → pos=−2, score=01000000. A repeat at −2 with bit 1 clear → pos=−3, score=10000000.
- Jump-the-light by right (right=1, leds_on=0) at pos=0 → pos=−1. winrnd with tie=1 → no change.
- pos=+2, boost at bit 5, proper push with mr=1 → step 1 (mover ahead), pos=+3. Next push → WIN_R, score=00000111, round_won one cycle, games_r=1.
- GAMES_TO_WIN=2: two right wins → match_over=1. next_round → games 0/0, PLAY, neutral. winrnd in the same cycle as next_round is ignored.
- rst asserted in WIN_L → PLAY, neutral, counters 0 next cycle.
- TOW_BOOST_EN undefined: the boost scenario above gives pos=−1 instead of −2.
